// File: rtl/gate_sequencer.sv
// Parking barrier sequencer: opens on a door request, holds, then closes, with travel timeouts and fault latch.
// Latency: one cycle from a sampled door_req to motor_up; outputs decode the registered state.
// Optional build macro GATE_AUTO_REOPEN_EN: an obstruction during closing reverses the barrier instead of pausing it.
module gate_sequencer #(
   parameter int HOLD_TIME  = 2000,
   parameter int TRAVEL_MAX = 3000
) (
   input  logic       clk,
   input  logic       rst,
   input  logic       door_req,
   input  logic       obstruct,
   input  logic       limit_open,
   input  logic       limit_closed,
   input  logic       fault_clr,
   output logic       motor_up,
   output logic       motor_down,
   output logic [2:0] gate_state,
   output logic       fault,
   output logic       gate_closed
);

   typedef enum logic [2:0] {
      CLOSED    = 3'd0,
      OPENING   = 3'd1,
      OPEN_HOLD = 3'd2,
      CLOSING   = 3'd3,
      FAULT     = 3'd4
   } state_t;

   // Terminal counts; the counter is compared against these before it wraps.
   localparam logic [11:0] HOLD_LAST   = 12'(HOLD_TIME - 1);
   localparam logic [11:0] TRAVEL_LAST = 12'(TRAVEL_MAX - 1);

   state_t      state;
   state_t      state_nxt;
   logic [11:0] cnt;
   logic [11:0] cnt_nxt;
   logic        sensor_conflict;

   // Both end stops active at once cannot be a real barrier position.
   assign sensor_conflict = limit_open & limit_closed;

   // State and counter registers; reset drops straight to a closed, idle barrier.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state <= CLOSED;
         cnt   <= '0;
      end else begin
         state <= state_nxt;
         cnt   <= cnt_nxt;
      end
   end

   // Next-state and counter update; any state change restarts the counter.
   always_comb begin
      state_nxt = state;
      cnt_nxt   = cnt;
      case (state)
         CLOSED: begin
            if (door_req) state_nxt = OPENING;
         end
         OPENING: begin
            if (limit_open)                state_nxt = OPEN_HOLD;
            else if (cnt == TRAVEL_LAST)   state_nxt = FAULT;
            else                           cnt_nxt   = cnt + 12'd1;
         end
         OPEN_HOLD: begin
            // Any request or a car under the barrier restarts the hold window,
            // so a held request keeps the counter pinned at zero.
            if (door_req || obstruct)      cnt_nxt   = '0;
            else if (cnt == HOLD_LAST)     state_nxt = CLOSING;
            else                           cnt_nxt   = cnt + 12'd1;
         end
         CLOSING: begin
            if (limit_closed) begin
               state_nxt = CLOSED;
            end else if (obstruct) begin
`ifdef GATE_AUTO_REOPEN_EN
               state_nxt = OPENING;
`else
               // Pause: stay in CLOSING with the counter frozen until the beam clears.
               cnt_nxt   = cnt;
`endif
            end else if (door_req) begin
               state_nxt = OPENING;
            end else if (cnt == TRAVEL_LAST) begin
               state_nxt = FAULT;
            end else begin
               cnt_nxt   = cnt + 12'd1;
            end
         end
         FAULT: begin
            // Only the acknowledge is honoured; resume by closing unless already down.
            if (fault_clr) state_nxt = limit_closed ? CLOSED : CLOSING;
         end
         default: begin
            state_nxt = FAULT;
         end
      endcase

      if ((state != FAULT) && sensor_conflict) state_nxt = FAULT;

      if (state_nxt != state) cnt_nxt = '0;
   end

   // Output decode from the registered state.
   always_comb begin
      motor_up    = (state == OPENING);
`ifdef GATE_AUTO_REOPEN_EN
      motor_down  = (state == CLOSING);
`else
      // The motor stops the moment the beam is broken, without waiting for an edge.
      motor_down  = (state == CLOSING) && !obstruct;
`endif
      fault       = (state == FAULT);
      gate_closed = (state == CLOSED);
      gate_state  = state;
   end

endmodule

// File: tb/tb_gate_sequencer.sv
// Directed bench for gate_sequencer with HOLD_TIME=5, TRAVEL_MAX=8.
// Inputs change 1 time unit after a rising edge; outputs are sampled at the same point.
// Every comparison goes through chk; one summary line at the end.
module tb_gate_sequencer;

   logic       clk;
   logic       rst;
   logic       door_req;
   logic       obstruct;
   logic       limit_open;
   logic       limit_closed;
   logic       fault_clr;
   logic       motor_up;
   logic       motor_down;
   logic [2:0] gate_state;
   logic       fault;
   logic       gate_closed;

   int n_chk = 0;
   int n_err = 0;

   gate_sequencer #(.HOLD_TIME(5), .TRAVEL_MAX(8)) dut (
      .clk          (clk),
      .rst          (rst),
      .door_req     (door_req),
      .obstruct     (obstruct),
      .limit_open   (limit_open),
      .limit_closed (limit_closed),
      .fault_clr    (fault_clr),
      .motor_up     (motor_up),
      .motor_down   (motor_down),
      .gate_state   (gate_state),
      .fault        (fault),
      .gate_closed  (gate_closed)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_chk++;
      if (got !== exp) begin
         n_err++;
         $display("FAIL %s: got %0d expected %0d", tag, got, exp);
      end
   endtask

   task automatic tick(input int n);
      for (int i = 0; i < n; i++) begin
         @(posedge clk);
         #1;
      end
   endtask

   initial begin
      rst = 1'b1; door_req = 1'b0; obstruct = 1'b0;
      limit_open = 1'b0; limit_closed = 1'b1; fault_clr = 1'b0;
      #12;
      chk("rst_state",  gate_state,  0);
      chk("rst_up",     motor_up,    0);
      chk("rst_down",   motor_down,  0);
      chk("rst_fault",  fault,       0);
      chk("rst_closed", gate_closed, 1);
      tick(1);
      rst = 1'b0;
      tick(1);
      chk("idle_state", gate_state, 0);

      // Nominal cycle
      door_req = 1'b1;
      tick(1);
      chk("nom_opening", gate_state, 1);
      chk("nom_up1",     motor_up,   1);
      door_req = 1'b0; limit_closed = 1'b0;
      tick(2);
      chk("nom_up3", motor_up, 1);
      limit_open = 1'b1;
      tick(1);
      chk("nom_hold",    gate_state, 2);
      chk("nom_up_off",  motor_up,   0);
      tick(4);
      chk("nom_hold4", gate_state, 2);
      tick(1);
      chk("nom_closing", gate_state, 3);
      chk("nom_down",    motor_down, 1);
      chk("nom_up_excl", motor_up,   0);
      limit_open = 1'b0;
      tick(2);
      limit_closed = 1'b1;
      tick(1);
      chk("nom_closed",     gate_state,  0);
      chk("nom_closed_ind", gate_closed, 1);

      // Hold extension: re-request exactly where the hold would otherwise end
      door_req = 1'b1;
      tick(1);
      door_req = 1'b0; limit_closed = 1'b0; limit_open = 1'b1;
      tick(1);
      chk("ext_hold", gate_state, 2);
      tick(4);
      door_req = 1'b1;
      tick(1);
      chk("ext_not_closing", gate_state, 2);
      door_req = 1'b0;
      tick(4);
      chk("ext_still_hold", gate_state, 2);
      tick(1);
      chk("ext_closing", gate_state, 3);
      limit_open = 1'b0;

      // Obstruction while closing (counter at 2)
      tick(2);
      obstruct = 1'b1;
`ifdef GATE_AUTO_REOPEN_EN
      tick(1);
      chk("obs_reopen", gate_state, 1);
      obstruct = 1'b0;
      tick(8);
      chk("obs_open_to", gate_state, 4);
`else
      #1;
      chk("obs_down_off", motor_down, 0);
      tick(10);
      chk("obs_paused",   gate_state, 3);
      chk("obs_down_off2", motor_down, 0);
      obstruct = 1'b0;
      #1;
      chk("obs_resume", motor_down, 1);
      tick(5);
      chk("obs_frozen", gate_state, 3);
      tick(1);
      chk("close_timeout", gate_state, 4);
`endif

      // Fault ignores everything but the acknowledge
      door_req = 1'b1;
      tick(2);
      chk("flt_ignore",  gate_state, 4);
      chk("flt_ind",     fault,      1);
      chk("flt_up",      motor_up,   0);
      chk("flt_down",    motor_down, 0);
      door_req = 1'b0; limit_closed = 1'b1; fault_clr = 1'b1;
      tick(1);
      chk("flt_clr_closed", gate_state, 0);
      fault_clr = 1'b0;

      // Open timeout
      door_req = 1'b1;
      tick(1);
      door_req = 1'b0; limit_closed = 1'b0;
      tick(7);
      chk("oto_still_opening", gate_state, 1);
      tick(1);
      chk("oto_fault",   gate_state, 4);
      chk("oto_fault_i", fault,      1);
      chk("oto_up",      motor_up,   0);
      fault_clr = 1'b1;
      tick(1);
      chk("oto_clr_closing", gate_state, 3);
      fault_clr = 1'b0; limit_closed = 1'b1;
      tick(1);
      chk("oto_closed", gate_state, 0);

      // Sensor contradiction in OPEN_HOLD
      door_req = 1'b1;
      tick(1);
      door_req = 1'b0; limit_closed = 1'b0; limit_open = 1'b1;
      tick(1);
      chk("con_hold", gate_state, 2);
      limit_closed = 1'b1;
      tick(1);
      chk("con_fault", gate_state, 4);
      limit_open = 1'b0; fault_clr = 1'b1;
      tick(1);
      chk("con_clr", gate_state, 0);
      fault_clr = 1'b0;

      // Reset between edges mid-opening
      door_req = 1'b1;
      tick(1);
      door_req = 1'b0; limit_closed = 1'b0;
      tick(1);
      chk("mid_opening", gate_state, 1);
      #3;
      rst = 1'b1;
      #1;
      chk("mid_rst_state", gate_state, 0);
      chk("mid_rst_up",    motor_up,   0);
      chk("mid_rst_closed", gate_closed, 1);
      tick(1);
      rst = 1'b0; door_req = 1'b1;
      tick(1);
      chk("post_rst_open", gate_state, 1);

      // Held request keeps the gate open indefinitely
      limit_open = 1'b1;
      tick(1);
      chk("held_hold", gate_state, 2);
      tick(20);
      chk("held_still", gate_state, 2);
      door_req = 1'b0;
      tick(4);
      chk("held_release_hold", gate_state, 2);
      tick(1);
      chk("held_closing", gate_state, 3);

      $display("Result: errors=%0d of %0d checks", n_err, n_chk);
      $finish;
   end

endmodule
